conv_fprop2_mul_arb: RTL and testbench

Round-robin arbiter that time-shares one signed 10s x 10s -> 10 multiplier among NREQ requesters inside conv_fprop2. Each requester presents an operand pair with a valid/ready handshake. The block accepts at most one pair per cycle, registers it, computes the truncated product, and returns it tagged with the requester id through a backpressured result port.

---
 rtl/conv_fprop2_pkg.sv | 18 +
 rtl/conv_fprop2_rr_pick.sv | 34 +++
 rtl/conv_fprop2_mul_arb.sv | 97 +++++++++
 tb/tb_conv_fprop2_mul_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fprop2_pkg.sv
// Shared widths and elaboration helpers for the conv_fprop2 datapath blocks.
package conv_fprop2_pkg;

  localparam int DIN_W    = 10;
  localparam int DOUT_W   = 10;
  localparam int NREQ_MAX = 8;

  // Smallest r with 2**r >= n; sizes requester id fields.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_fprop2_rr_pick.sv
// Round-robin winner selection: the search starts one slot past the previous winner.
module conv_fprop2_rr_pick
  import conv_fprop2_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  // First requester found after rr_ptr (wrapping) takes the one-hot grant.
  always_comb begin
    int idx_s;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx_s  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(rr_ptr) + k) % NREQ;
      if (req[idx_s] && !any) begin
        any          = 1'b1;
        grant[idx_s] = 1'b1;
        winner       = ID_W'(idx_s);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/conv_fprop2_mul_arb.sv
// Shares one signed truncating multiplier among NREQ requesters through a
// round-robin arbiter and a two-stage (operand / result) pipeline.
module conv_fprop2_mul_arb
  import conv_fprop2_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DIN_W  = conv_fprop2_pkg::DIN_W,
  parameter int DOUT_W = conv_fprop2_pkg::DOUT_W,
  parameter int ID_W   = clog2(NREQ),
  parameter int CNT_W  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIN_W-1:0] req_a,
  input  logic [NREQ*DIN_W-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DOUT_W-1:0]     res_data,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      acc_cnt
);

  logic              en_s;
  logic              accept_s;
  logic              any_s;
  logic [NREQ-1:0]   grant_s;
  logic [ID_W-1:0]   winner_s;
  logic [DOUT_W-1:0] prod_lo_s;

  logic [ID_W-1:0]   rr_ptr_r;
  logic              s1_valid_r;
  logic [DIN_W-1:0]  s1_a_r;
  logic [DIN_W-1:0]  s1_b_r;
  logic [ID_W-1:0]   s1_id_r;
  logic              s2_valid_r;
  logic [DOUT_W-1:0] res_data_r;
  logic [ID_W-1:0]   res_id_r;
  logic [CNT_W-1:0]  acc_cnt_r;

  conv_fprop2_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .grant  (grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // The pipeline only moves when the result slot is empty or being drained.
  assign en_s      = ~s2_valid_r | res_ready;
  assign req_ready = en_s ? grant_s : {NREQ{1'b0}};
  assign accept_s  = |(req_valid & req_ready);

  // Only the low DOUT_W bits are kept, so overflow wraps in two's complement.
  assign prod_lo_s = DOUT_W'($signed(s1_a_r) * $signed(s1_b_r));

  // Arbiter pointer, accept counter and both pipeline stages.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_r   <= ID_W'(NREQ - 1);
      acc_cnt_r  <= {CNT_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_a_r     <= {DIN_W{1'b0}};
      s1_b_r     <= {DIN_W{1'b0}};
      s1_id_r    <= {ID_W{1'b0}};
      s2_valid_r <= 1'b0;
      res_data_r <= {DOUT_W{1'b0}};
      res_id_r   <= {ID_W{1'b0}};
    end else begin
      if (accept_s) begin
        rr_ptr_r  <= winner_s;
        acc_cnt_r <= acc_cnt_r + CNT_W'(1'b1);
        s1_a_r    <= req_a[int'(winner_s)*DIN_W +: DIN_W];
        s1_b_r    <= req_b[int'(winner_s)*DIN_W +: DIN_W];
        s1_id_r   <= winner_s;
      end
      if (en_s) begin
        s1_valid_r <= accept_s;
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          res_data_r <= prod_lo_s;
          res_id_r   <= s1_id_r;
        end
      end
    end
  end

  assign res_valid = s2_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign acc_cnt   = acc_cnt_r;

endmodule

// File: tb/tb_conv_fprop2_mul_arb.sv
// Directed plus random stimulus for conv_fprop2_mul_arb, checked against a
// cycle model of the arbiter and a queue of expected results.
module tb_conv_fprop2_mul_arb;

  localparam int NREQ   = 4;
  localparam int DIN_W  = 10;
  localparam int DOUT_W = 10;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 16;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIN_W-1:0] req_a;
  logic [NREQ*DIN_W-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [DOUT_W-1:0]     res_data;
  logic [ID_W-1:0]       res_id;
  logic [CNT_W-1:0]      acc_cnt;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DOUT_W-1:0] data;
  } res_t;

  res_t              exp_q[$];
  logic              m_s1v;
  logic              m_s2v;
  logic [ID_W-1:0]   m_ptr;
  logic [CNT_W-1:0]  m_cnt;
  int                checks = 0;
  int                errors = 0;

  always #5 ap_clk = ~ap_clk;

  conv_fprop2_mul_arb #(
    .NREQ   (NREQ),
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .acc_cnt   (acc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input logic [ID_W-1:0] p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (int'(p) + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*DIN_W +: DIN_W] = DIN_W'(a);
    req_b[i*DIN_W +: DIN_W] = DIN_W'(b);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end
  endtask

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic cycle();
    int                      w;
    logic                    en;
    logic [NREQ-1:0]         exp_rdy;
    logic signed [DIN_W-1:0] ea;
    logic signed [DIN_W-1:0] eb;
    logic [31:0]             full;
    res_t                    r;
    #1;
    en      = !m_s2v || res_ready;
    w       = pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (en && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_s2v && exp_q.size() > 0) begin
      chk("res_data", 32'(res_data), 32'(exp_q[0].data));
      chk("res_id", 32'(res_id), 32'(exp_q[0].id));
    end
    if (ap_rst) begin
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      m_ptr = ID_W'(NREQ - 1);
      m_cnt = '0;
      exp_q.delete();
    end else begin
      if (m_s2v && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_rdy != '0) begin
        ea     = req_a[w*DIN_W +: DIN_W];
        eb     = req_b[w*DIN_W +: DIN_W];
        full   = 32'(int'(ea) * int'(eb));
        r.id   = ID_W'(w);
        r.data = full[DOUT_W-1:0];
        exp_q.push_back(r);
        m_ptr  = ID_W'(w);
        m_cnt  = m_cnt + 16'd1;
      end
      if (en) begin
        m_s2v = m_s1v;
        m_s1v = (exp_rdy != '0);
      end
    end
    @(posedge ap_clk);
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_s2v));
    chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    @(negedge ap_clk);
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    res_ready = 1'b0;
    req_valid = '0;
    cycle();
    ap_rst    = 1'b0;
    res_ready = 1'b1;
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    chk("rst_res_id", 32'(res_id), 32'h0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    m_s1v  = 1'b0;
    m_s2v  = 1'b0;
    m_ptr  = ID_W'(NREQ - 1);
    m_cnt  = '0;

    // Single request: -3 * 7 = -21
    set_op(0, 10'h3FD, 7);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    chk("single_lat1", 32'(res_valid), 32'h0);
    cycle();
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_data", 32'(res_data), 32'h3EB);
    chk("single_id", 32'(res_id), 32'h0);
    chk("single_cnt", 32'(acc_cnt), 32'h1);
    cycle();

    // Overflow wrap of the truncated product
    set_op(3, 100, 100);
    req_valid = 4'b1000;
    cycle();
    set_op(3, -512, -1);
    cycle();
    req_valid = '0;
    chk("ovf_data0", 32'(res_data), 32'h310);
    chk("ovf_id0", 32'(res_id), 32'h3);
    cycle();
    chk("ovf_data1", 32'(res_data), 32'h200);
    repeat (2) cycle();

    // Fairness from a freshly reset pointer
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      #1;
      chk("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      cycle();
    end
    req_valid = '0;
    chk("fair_cnt", 32'(acc_cnt), 32'd8);
    repeat (3) cycle();

    // Backpressure with a full pipeline
    req_valid = 4'b1111;
    rand_ops();
    repeat (2) cycle();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      cycle();
      chk("bp_cnt", 32'(acc_cnt), 32'd10);
    end
    res_ready = 1'b1;
    req_valid = '0;
    repeat (3) cycle();

    // Reset mid-operation
    req_valid = 4'b1111;
    rand_ops();
    repeat (2) cycle();
    do_reset();
    chk("midrst_valid", 32'(res_valid), 32'h0);
    chk("midrst_cnt", 32'(acc_cnt), 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("midrst_first", 32'(req_ready), 32'h1);
    repeat (2) cycle();

    // Idle must leave the pointer alone: next winner after 1 is 2
    req_valid = '0;
    repeat (5) cycle();
    req_valid = 4'b1111;
    #1;
    chk("idle_ptr", 32'(req_ready), 32'h4);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      res_ready = 1'($urandom_range(0, 1));
      rand_ops();
      cycle();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) cycle();

    // Accept counter wrap
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 65535; k++) begin
      set_op(k % NREQ, k, k + 1);
      cycle();
    end
    chk("wrap_max", 32'(acc_cnt), 32'hFFFF);
    cycle();
    chk("wrap_zero", 32'(acc_cnt), 32'h0);
    req_valid = '0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
